serial_subtractor: RTL and testbench

Multi-cycle 64-bit unsigned/two's-complement subtractor computing `diff = a - b` one 8-bit slice per clock, least-significant slice first, with a rippling borrow register. It is the inverse datapath to the lab's combinational 64-bit adder. It sits behind a valid/ready handshake on both sides, so an upstream stage can issue operands and a downstream stage can apply backpressure on results.

---
 rtl/serial_subtractor_pkg.sv | 15 +
 rtl/serial_subtractor_if.sv | 27 ++
 rtl/serial_subtractor_sub_slice.sv | 18 +
 rtl/serial_subtractor.sv | 120 ++++++++++++
 tb/tb_serial_subtractor.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared constants and state encoding for the slice-serial subtractor.
package serial_sub_pkg;

    localparam int WIDTH  = 64;
    localparam int SLICE  = 8;
    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = $clog2(NSLICE);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle between upstream, subtractor and downstream.
interface serial_subtractor_if #(
    parameter int WIDTH = 64
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             zero;
    logic             overflow;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow, zero, overflow
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow, zero, overflow
    );

endinterface

// File: rtl/serial_subtractor_sub_slice.sv
// One slice of the ripple-borrow subtractor: {bout, d} = x - y - bin.
module sub_slice #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] i_x,
    input  logic [SLICE-1:0] i_y,
    input  logic             i_bin,
    output logic [SLICE-1:0] o_d,
    output logic             o_bout
);

    logic [SLICE:0] w_res;

    assign w_res  = {1'b0, i_x} - {1'b0, i_y} - (SLICE+1)'(i_bin);
    assign o_d    = w_res[SLICE-1:0];
    assign o_bout = w_res[SLICE];

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: one SLICE per clock, LS slice first, with a
// registered borrow rippling between slices.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = serial_sub_pkg::WIDTH,
    parameter int SLICE = serial_sub_pkg::SLICE
) (
    input logic               clk,
    input logic               rst,
    serial_subtractor_if.slave s
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

    state_t r_state;
    state_t w_state_nxt;

    logic [NSLICE-1:0][SLICE-1:0] r_a;
    logic [NSLICE-1:0][SLICE-1:0] r_b;
    logic [NSLICE-1:0][SLICE-1:0] r_diff;
    logic [NSLICE-1:0][SLICE-1:0] w_diff_nxt;
    logic [CNT_W-1:0]             r_cnt;
    logic                         r_borrow;
    logic                         r_zero;
    logic                         r_ovf;

    logic             w_in_ready;
    logic             w_out_valid;
    logic [SLICE-1:0] w_d;
    logic             w_bout;

    sub_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .i_x    (r_a[r_cnt]),
        .i_y    (r_b[r_cnt]),
        .i_bin  (r_borrow),
        .o_d    (w_d),
        .o_bout (w_bout)
    );

    // Full result as it will look once the current slice is written;
    // flags are taken from this on the final slice.
    always_comb begin
        w_diff_nxt        = r_diff;
        w_diff_nxt[r_cnt] = w_d;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (s.in_valid) w_state_nxt = RUN;
            end
            RUN: begin
                if (r_cnt == LAST) w_state_nxt = DONE;
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (s.out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (s.in_valid) begin
                        r_a      <= s.a;
                        r_b      <= s.b;
                        r_cnt    <= '0;
                        r_borrow <= 1'b0;
                        r_zero   <= 1'b0;
                        r_ovf    <= 1'b0;
                    end
                end
                RUN: begin
                    r_diff[r_cnt] <= w_d;
                    r_borrow      <= w_bout;
                    r_cnt         <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_zero <= (w_diff_nxt == '0);
                        r_ovf  <= (r_a[NSLICE-1][SLICE-1] != r_b[NSLICE-1][SLICE-1])
                               && (w_diff_nxt[NSLICE-1][SLICE-1] != r_a[NSLICE-1][SLICE-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign s.in_ready  = w_in_ready;
    assign s.out_valid = w_out_valid;
    assign s.diff      = r_diff;
    assign s.borrow    = r_borrow;
    assign s.zero      = r_zero;
    assign s.overflow  = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor.
module tb_serial_subtractor;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    serial_subtractor_if #(.WIDTH(64)) bus ();

    serial_subtractor #(
        .WIDTH (64),
        .SLICE (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .s   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one operation with out_ready high, captures the result at the
    // first cycle out_valid is seen, then lets the handshake complete.
    task automatic run_op(
        input  logic [63:0] ta,
        input  logic [63:0] tb_,
        output logic [63:0] d,
        output logic        bw,
        output logic        z,
        output logic        ov,
        output int          lat,
        output logic        ir_busy,
        output logic        ir_after,
        output bit          to
    );
        @(negedge clk);
        bus.a         = ta;
        bus.b         = tb_;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        ir_busy = bus.in_ready;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        to = !bus.out_valid;
        d  = bus.diff;
        bw = bus.borrow;
        z  = bus.zero;
        ov = bus.overflow;
        @(negedge clk);
        ir_after = bus.in_ready;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hs got ir=%b ov=%b exp ir=1 ov=0",
                     bus.in_ready, bus.out_valid);
        end
        checks++;
        if ({bus.diff, bus.borrow, bus.zero, bus.overflow} !== 67'd0) begin
            failures++;
            $display("FAIL reset_out got diff=%h b=%b z=%b o=%b exp all 0",
                     bus.diff, bus.borrow, bus.zero, bus.overflow);
        end
    endtask

    task automatic test_basic();
        logic [63:0] d;
        logic bw, z, ov, irb, ira;
        int lat;
        bit to;
        run_op(64'h02, 64'h01, d, bw, z, ov, lat, irb, ira, to);
        checks++;
        if (to || lat != 8) begin
            failures++;
            $display("FAIL basic_latency got=%0d timeout=%0b exp=8", lat, to);
        end
        checks++;
        if (irb !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy got in_ready=%b exp=0", irb);
        end
        checks++;
        if ({d, bw, z, ov} !== {64'h01, 3'b000}) begin
            failures++;
            $display("FAIL basic_result got diff=%h b=%b z=%b o=%b exp 1/0/0/0",
                     d, bw, z, ov);
        end
        checks++;
        if (ira !== 1'b1) begin
            failures++;
            $display("FAIL basic_ready_after got=%b exp=1", ira);
        end
    endtask

    task automatic test_wrap();
        logic [63:0] d;
        logic bw, z, ov, irb, ira;
        int lat;
        bit to;
        run_op(64'h01, 64'h02, d, bw, z, ov, lat, irb, ira, to);
        checks++;
        if (to || {d, bw, z, ov} !== {64'hFFFF_FFFF_FFFF_FFFF, 3'b100}) begin
            failures++;
            $display("FAIL wrap got diff=%h b=%b z=%b o=%b to=%b exp ffff..ffff/1/0/0",
                     d, bw, z, ov, to);
        end
    endtask

    task automatic test_equal();
        logic [63:0] d;
        logic bw, z, ov, irb, ira;
        int lat;
        bit to;
        run_op(64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567,
               d, bw, z, ov, lat, irb, ira, to);
        checks++;
        if (to || {d, bw, z, ov} !== {64'h0, 3'b010}) begin
            failures++;
            $display("FAIL equal got diff=%h b=%b z=%b o=%b to=%b exp 0/0/1/0",
                     d, bw, z, ov, to);
        end
    endtask

    task automatic test_overflow();
        logic [63:0] d;
        logic bw, z, ov, irb, ira;
        int lat;
        bit to;
        run_op(64'h8000_0000_0000_0000, 64'h01, d, bw, z, ov, lat, irb, ira, to);
        checks++;
        if (to || {d, bw, z, ov} !== {64'h7FFF_FFFF_FFFF_FFFF, 3'b001}) begin
            failures++;
            $display("FAIL overflow got diff=%h b=%b z=%b o=%b to=%b exp 7fff..ffff/0/0/1",
                     d, bw, z, ov, to);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] exp_d;
        int lat;
        exp_d = 64'h0246_8ACF_1357_9BCF;
        @(negedge clk);
        bus.a         = 64'h1234_5678_9ABC_DEF0;
        bus.b         = 64'h0FED_CBA9_8765_4321;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        // Garbage operands and a held request while busy
        bus.a = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.b = 64'h0;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 8) begin
            failures++;
            $display("FAIL bp_latency got=%0d exp=8", lat);
        end
        for (int i = 0; i < 5; i++) begin
            bus.a = 64'h5555_0000_AAAA_0000 + 64'(i);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                {bus.diff, bus.borrow, bus.zero, bus.overflow} !== {exp_d, 3'b000}) begin
                failures++;
                $display("FAIL bp_hold[%0d] got ov=%b ir=%b diff=%h b=%b z=%b o=%b exp 1/0/%h/0/0/0",
                         i, bus.out_valid, bus.in_ready, bus.diff, bus.borrow,
                         bus.zero, bus.overflow, exp_d);
            end
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release got ir=%b ov=%b exp ir=1 ov=0",
                     bus.in_ready, bus.out_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_no_reaccept got in_ready=%b exp=1", bus.in_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] d;
        logic bw, z, ov, irb, ira;
        int lat;
        bit to;
        @(negedge clk);
        bus.a         = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.b         = 64'h01;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_hs got ir=%b ov=%b exp ir=1 ov=0",
                     bus.in_ready, bus.out_valid);
        end
        checks++;
        if ({bus.diff, bus.borrow, bus.zero, bus.overflow} !== 67'd0) begin
            failures++;
            $display("FAIL midrst_out got diff=%h b=%b z=%b o=%b exp all 0",
                     bus.diff, bus.borrow, bus.zero, bus.overflow);
        end
        run_op(64'h10, 64'h03, d, bw, z, ov, lat, irb, ira, to);
        checks++;
        if (to || {d, bw, z, ov} !== {64'h0D, 3'b000}) begin
            failures++;
            $display("FAIL midrst_fresh got diff=%h b=%b z=%b o=%b to=%b exp d/0/0/0",
                     d, bw, z, ov, to);
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_equal();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
